esc_i2c_master: RTL and testbench

// - I2C initiator for the ESC's I2C responder (setpoint/status registers over SCL/SDA).
// - Executes one single-register write or read per request; used in the board controller and as the bench driver.
// - Open-drain outputs: an _oe high pulls the line low, and the line floats high otherwise.
// - No clock stretching, because the ESC samples SCL as an input only.

---
 rtl/esc_i2c_master.sv | 218 +++++++++++++++++++++
 tb/tb_esc_i2c_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/esc_i2c_master.sv
// esc_i2c_master: single-register I2C initiator for the ESC responder.
// Each request runs one register write or one register read, with a
// repeated START for reads. Both bus lines are open-drain: an _oe output
// at 1 pulls the line low, and the line floats high when it is 0.
// Each bus bit is four quarters of CLK_DIV clk cycles.
// Optional feature: define ESC_I2C_MASTER_RETRY_EN to retry an address
// NACK in ACK1 up to three times before ack_err is reported.
module esc_i2c_master #(
  parameter int         CLK_DIV  = 16,
  parameter logic [6:0] DEV_ADDR = 7'h10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  // S_RWAIT is only reachable when address retries are enabled.
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDRW, S_ACK1, S_REG, S_ACK2, S_WDATA, S_ACK3,
    S_RSTART, S_ADDRR, S_ACK4, S_RDATA, S_MNACK, S_STOP, S_RWAIT
  } state_t;

  state_t        r_state, w_next;
  logic [DW-1:0] r_div;
  logic [1:0]    r_q;        // quarter within the current bit
  logic [2:0]    r_bit;      // bit within the current byte
  logic [7:0]    r_sh;       // transmit / receive shift register
  logic          r_rw;
  logic [7:0]    r_reg;
  logic [7:0]    r_wdat;
  logic          r_nack;     // last ACK slot sampled high
  logic          r_busy;
  logic          r_done;
  logic          r_ack_err;
  logic [7:0]    r_rd_data;

  logic w_tick, w_samp, w_qend, w_byte_end, w_accept, w_tx, w_ack;
  logic w_retry_pend, w_scl_oe, w_sda_oe, w_scl_low;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_tick     = (r_state != S_IDLE) && (r_div == DW'(CLK_DIV - 1));
  assign w_samp     = w_tick && (r_q == 2'd2);
  assign w_qend     = w_tick && (r_q == 2'd3);
  assign w_byte_end = w_qend && (r_bit == 3'd7);
  assign w_tx       = r_state inside {S_ADDRW, S_REG, S_WDATA, S_ADDRR};
  assign w_ack      = r_state inside {S_ACK1, S_ACK2, S_ACK3, S_ACK4};

`ifdef ESC_I2C_MASTER_RETRY_EN
  logic       r_retry;
  logic [1:0] r_tries;

  assign w_retry_pend = r_retry;

  // Count ACK1 NACKs and hold the pending-retry flag across the STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retry <= 1'b0;
      r_tries <= 2'd0;
    end else if (w_accept) begin
      r_retry <= 1'b0;
      r_tries <= 2'd0;
    end else if ((r_state == S_ACK1) && w_qend && r_nack && (r_tries != 2'd3)) begin
      r_retry <= 1'b1;
      r_tries <= r_tries + 2'd1;
    end else if ((r_state == S_STOP) && w_qend) begin
      r_retry <= 1'b0;
    end
  end
`else
  assign w_retry_pend = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the values from before the edge.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state sequencing through the transaction.
  always_comb begin
    // NOTE: the default first means every path assigns w_next, so no
    // latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start)      w_next = S_START;
      S_START:  if (w_qend)     w_next = S_ADDRW;
      S_ADDRW:  if (w_byte_end) w_next = S_ACK1;
      S_ACK1:   if (w_qend)     w_next = r_nack ? S_STOP : S_REG;
      S_REG:    if (w_byte_end) w_next = S_ACK2;
      S_ACK2:   if (w_qend)     w_next = r_nack ? S_STOP : (r_rw ? S_RSTART : S_WDATA);
      S_WDATA:  if (w_byte_end) w_next = S_ACK3;
      S_ACK3:   if (w_qend)     w_next = S_STOP;
      S_RSTART: if (w_qend)     w_next = S_ADDRR;
      S_ADDRR:  if (w_byte_end) w_next = S_ACK4;
      S_ACK4:   if (w_qend)     w_next = r_nack ? S_STOP : S_RDATA;
      S_RDATA:  if (w_byte_end) w_next = S_MNACK;
      S_MNACK:  if (w_qend)     w_next = S_STOP;
      S_STOP:   if (w_qend)     w_next = w_retry_pend ? S_RWAIT : S_IDLE;
      S_RWAIT:  if (w_qend)     w_next = S_START;
      default:                  w_next = S_IDLE;
    endcase
  end

  // Line drive: SCL low in q0/q1 of every clocked bit; SDA per state.
  always_comb begin
    w_scl_oe  = 1'b0;
    w_sda_oe  = 1'b0;
    w_scl_low = (r_q == 2'd0) || (r_q == 2'd1);
    unique case (r_state)
      S_START: w_sda_oe = r_q[1];
      S_ADDRW, S_REG, S_WDATA, S_ADDRR: begin
        w_scl_oe = w_scl_low;
        w_sda_oe = ~r_sh[7];
      end
      S_ACK1, S_ACK2, S_ACK3, S_ACK4, S_RDATA, S_MNACK:
        w_scl_oe = w_scl_low;
      S_RSTART: begin
        w_scl_oe = w_scl_low;
        w_sda_oe = (r_q == 2'd3);
      end
      S_STOP: begin
        w_scl_oe = w_scl_low;
        w_sda_oe = (r_q != 2'd3);
      end
      default: ;
    endcase
  end

  // Divider, bit position, operand latch, shift register and completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_q       <= 2'd0;
      r_bit     <= 3'd0;
      r_sh      <= 8'h00;
      r_rw      <= 1'b0;
      r_reg     <= 8'h00;
      r_wdat    <= 8'h00;
      r_nack    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_rd_data <= 8'h00;
    end else begin
      r_done <= 1'b0;

      if ((r_state == S_IDLE) || w_tick) r_div <= '0;
      else                               r_div <= r_div + 1'b1;

      if (w_next != r_state) begin
        r_q   <= 2'd0;
        r_bit <= 3'd0;
      end else if (w_tick) begin
        r_q <= r_q + 2'd1;
        if (r_q == 2'd3) r_bit <= r_bit + 3'd1;
      end

      if (w_accept) begin
        r_rw      <= rw;
        r_reg     <= reg_addr;
        r_wdat    <= wr_data;
        r_ack_err <= 1'b0;
        r_nack    <= 1'b0;
        r_busy    <= 1'b1;
      end

      // Load each outgoing byte on entry; shift out at bit end, in at q2 end.
      if (w_next != r_state) begin
        unique case (w_next)
          S_ADDRW: r_sh <= {DEV_ADDR, 1'b0};
          S_REG:   r_sh <= r_reg;
          S_WDATA: r_sh <= r_wdat;
          S_ADDRR: r_sh <= {DEV_ADDR, 1'b1};
          default: ;
        endcase
      end else if (w_qend && w_tx) begin
        r_sh <= {r_sh[6:0], 1'b0};
      end else if (w_samp && (r_state == S_RDATA)) begin
        r_sh <= {r_sh[6:0], sda_in};
      end

      if (w_samp && w_ack) r_nack <= sda_in;

      if ((r_state == S_STOP) && w_qend) begin
        if (w_retry_pend) begin
          r_nack <= 1'b0;
        end else begin
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_ack_err <= r_nack;
          if (r_rw && !r_nack) r_rd_data <= r_sh;
        end
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign ack_err = r_ack_err;
  assign rd_data = r_rd_data;
  assign scl_oe  = w_scl_oe;
  assign sda_oe  = w_sda_oe;

endmodule

// File: tb/tb_esc_i2c_master.sv
// tb_esc_i2c_master: directed bench for esc_i2c_master with CLK_DIV=4.
// A behavioural I2C responder on the open-drain bus logs received bytes,
// ACKs when present and returns rdval on reads; the same sampler counts
// START/STOP conditions, done pulses and SCL phase-length violations.
module tb_esc_i2c_master;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       busy, done, ack_err, scl_oe, sda_oe, sda_in;
  logic [7:0] rd_data;

  logic slv_pull = 1'b0;
  logic scl_line, sda_line;
  assign scl_line = ~scl_oe;
  assign sda_line = ~(sda_oe | slv_pull);
  assign sda_in   = sda_line;

  esc_i2c_master #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .reg_addr(reg_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .ack_err(ack_err),
    .rd_data(rd_data), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Responder and bus monitor state.
  logic       present = 1'b1;
  logic [7:0] rdval = 8'hA5;
  logic [7:0] log_b [0:63];
  int nlog = 0, nstart = 0, nstop = 0, ndone = 0, viol = 0, mack = -1;
  logic ps = 1'b1, pd = 1'b1;
  int   run = 0;
  logic run_sda_chg = 1'b0, run_skip = 1'b1;
  logic s_active = 1'b0, s_first = 1'b0, s_go_rd = 1'b0, s_rd = 1'b0;
  int   s_bitcnt = 0;
  logic [7:0] s_byte = 8'h00, s_tx = 8'h00;

  // Sample the bus mid-cycle; the responder only moves SDA after SCL falls.
  always @(negedge clk) begin
    logic s, d;
    s = scl_line;
    d = sda_line;
    if (!rst_n) begin
      s_active = 1'b0; slv_pull = 1'b0; run_skip = 1'b1; run = 0;
    end else begin
      if (done) ndone++;
      if (s != ps) begin
        if (!run_skip) begin
          if (!ps && run != 2*CLK_DIV) viol++;
          if (ps && !run_sda_chg && run != 2*CLK_DIV) viol++;
        end
        run = 1; run_sda_chg = 1'b0; run_skip = 1'b0;
      end else begin
        run++;
        if (d != pd) run_sda_chg = 1'b1;
      end
      if (ps && s && pd && !d) begin
        nstart++; s_active = 1'b1; s_bitcnt = 0; s_first = 1'b1;
        s_rd = 1'b0; s_go_rd = 1'b0; slv_pull = 1'b0;
      end else if (ps && s && !pd && d) begin
        nstop++; s_active = 1'b0; slv_pull = 1'b0;
      end else if (s_active && !ps && s) begin
        if (s_bitcnt < 8) begin
          if (!s_rd) s_byte = {s_byte[6:0], d};
          s_bitcnt++;
          if (s_bitcnt == 8 && !s_rd) begin
            if (nlog < 64) log_b[nlog] = s_byte;
            nlog++;
            if (s_first && s_byte[0] && present) s_go_rd = 1'b1;
            s_first = 1'b0;
          end
        end else if (s_bitcnt == 8) begin
          if (s_rd) begin
            mack = int'(d);
            if (d) s_rd = 1'b0;
          end
          s_bitcnt = 9;
        end
      end else if (s_active && ps && !s) begin
        if (s_bitcnt == 8) begin
          slv_pull = s_rd ? 1'b0 : present;
        end else if (s_bitcnt == 9) begin
          s_bitcnt = 0;
          slv_pull = 1'b0;
          if (s_go_rd) begin s_rd = 1'b1; s_go_rd = 1'b0; s_tx = rdval; end
          if (s_rd) begin slv_pull = ~s_tx[7]; s_tx = {s_tx[6:0], 1'b0}; end
        end else if (s_rd && s_bitcnt >= 1 && s_bitcnt <= 7) begin
          slv_pull = ~s_tx[7]; s_tx = {s_tx[6:0], 1'b0};
        end
      end
    end
    ps = s;
    pd = d;
  end

  // One request: lat = edges from accept to done (-1 on timeout, -2 when
  // reset was injected). poke_at re-pulses start while busy; rst_at resets.
  task automatic xfer(input logic r, input logic [7:0] ra, input logic [7:0] wd,
                      input int poke_at, input int rst_at,
                      output int lat, output logic aerr, output logic bsy);
    lat = -1; aerr = 1'bx; bsy = 1'bx;
    @(negedge clk);
    start = 1'b1; rw = r; reg_addr = ra; wr_data = wd;
    @(posedge clk); #1;
    start = 1'b0; rw = 1'b0; reg_addr = 8'h00; wr_data = 8'h00;
    check("busy_on_accept", busy, 1'b1);
    for (int n = 1; n <= 4000; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; aerr = ack_err; bsy = busy; break; end
      if (n == poke_at) begin start = 1'b1; rw = 1'b1; reg_addr = 8'h55; wr_data = 8'h33; end
      if (n == poke_at + 1) begin start = 1'b0; rw = 1'b0; reg_addr = 8'h00; wr_data = 8'h00; end
      if (n == rst_at) begin
        rst_n = 1'b0; #1;
        check("rst_scl_oe", scl_oe, 1'b0);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        lat = -2;
        break;
      end
    end
  endtask

  int   lat, b_log, b_start, b_stop, b_done, b_viol;
  logic aerr, bsy;

  task automatic mark();
    b_log = nlog; b_start = nstart; b_stop = nstop; b_done = ndone; b_viol = viol;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_ack_err", ack_err, 1'b0);
    check("reset_rd_data", rd_data, 8'h00);
    check("reset_scl_oe", scl_oe, 1'b0);
    check("reset_sda_oe", sda_oe, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Write reg 01 = 80.
    mark();
    xfer(1'b0, 8'h01, 8'h80, 0, 0, lat, aerr, bsy);
    repeat (20) @(posedge clk); #1;
    check("wr_latency", lat, 464);
    check("wr_ack_err", aerr, 1'b0);
    check("wr_busy_at_done", bsy, 1'b0);
    check("wr_nbytes", nlog - b_log, 3);
    check("wr_byte0", log_b[b_log], 8'h20);
    check("wr_byte1", log_b[b_log+1], 8'h01);
    check("wr_byte2", log_b[b_log+2], 8'h80);
    check("wr_starts", nstart - b_start, 1);
    check("wr_stops", nstop - b_stop, 1);
    check("wr_dones", ndone - b_done, 1);
    check("wr_bus_timing", viol - b_viol, 0);

    // Read reg 02, responder returns A5.
    mark(); rdval = 8'hA5; mack = -1;
    xfer(1'b1, 8'h02, 8'h00, 0, 0, lat, aerr, bsy);
    repeat (20) @(posedge clk); #1;
    check("rd_latency", lat, 624);
    check("rd_ack_err", aerr, 1'b0);
    check("rd_data", rd_data, 8'hA5);
    check("rd_nbytes", nlog - b_log, 3);
    check("rd_byte0", log_b[b_log], 8'h20);
    check("rd_byte1", log_b[b_log+1], 8'h02);
    check("rd_byte2", log_b[b_log+2], 8'h21);
    check("rd_starts", nstart - b_start, 2);
    check("rd_stops", nstop - b_stop, 1);
    check("rd_master_nack", mack, 1);
    check("rd_dones", ndone - b_done, 1);
    check("rd_bus_timing", viol - b_viol, 0);

    // Responder absent: address NACK.
    mark(); present = 1'b0; rdval = 8'h3C;
    xfer(1'b1, 8'h02, 8'h00, 0, 0, lat, aerr, bsy);
    repeat (20) @(posedge clk); #1;
`ifdef ESC_I2C_MASTER_RETRY_EN
    check("nack_latency", lat, 752);
    check("nack_starts", nstart - b_start, 4);
    check("nack_stops", nstop - b_stop, 4);
    check("nack_nbytes", nlog - b_log, 4);
`else
    check("nack_latency", lat, 176);
    check("nack_starts", nstart - b_start, 1);
    check("nack_stops", nstop - b_stop, 1);
    check("nack_nbytes", nlog - b_log, 1);
`endif
    check("nack_ack_err_at_done", aerr, 1'b1);
    check("nack_ack_err_held", ack_err, 1'b1);
    check("nack_rd_data_kept", rd_data, 8'hA5);
    check("nack_dones", ndone - b_done, 1);
    check("nack_bus_timing", viol - b_viol, 0);
    present = 1'b1;

    // Second start while busy is ignored.
    mark();
    xfer(1'b0, 8'h01, 8'h80, 100, 0, lat, aerr, bsy);
    repeat (40) @(posedge clk); #1;
    check("busy_latency", lat, 464);
    check("busy_ack_err_cleared", aerr, 1'b0);
    check("busy_nbytes", nlog - b_log, 3);
    check("busy_byte1", log_b[b_log+1], 8'h01);
    check("busy_byte2", log_b[b_log+2], 8'h80);
    check("busy_dones", ndone - b_done, 1);
    check("busy_idle_after", busy, 1'b0);

    // Reset during the REG byte, then a clean write.
    xfer(1'b0, 8'h07, 8'h11, 0, 200, lat, aerr, bsy);
    check("rst_injected", lat, 32'hFFFF_FFFE);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    mark();
    xfer(1'b0, 8'h03, 8'h5A, 0, 0, lat, aerr, bsy);
    repeat (20) @(posedge clk); #1;
    check("post_rst_latency", lat, 464);
    check("post_rst_ack_err", aerr, 1'b0);
    check("post_rst_nbytes", nlog - b_log, 3);
    check("post_rst_byte1", log_b[b_log+1], 8'h03);
    check("post_rst_byte2", log_b[b_log+2], 8'h5A);
    check("post_rst_bus_timing", viol - b_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
